// File: rtl/neighbor_counter_pkg.sv
// Shared minesweeper board constants, neighbour offset table and the
// neighbour-count FSM state type.
package neighbor_counter_pkg;

  localparam int COLS = 16;
  localparam int ROWS = 16;
  localparam logic [3:0] MINE_CODE = 4'hF;
  localparam int NUM_PROBES = 9;

  function automatic int addr_width(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  // Probe order: centre first, then the 8 neighbours in row-major order.
  localparam logic signed [1:0] DR_TAB [NUM_PROBES] =
    '{2'sd0, -2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};
  localparam logic signed [1:0] DC_TAB [NUM_PROBES] =
    '{2'sd0, -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/neighbor_counter_if.sv
// Bus between the neighbour counter, the mine bitmap RAM, the count RAM
// and the game controller that kicks off a scan.
interface neighbor_counter_if #(
  parameter int ADDR_W = 8
);
  // start: one-cycle pulse, only honoured while the counter is idle.
  // mine_rd_data is valid exactly one cycle after a cycle with mine_re high.
  // cnt_we is a single-cycle write strobe with no backpressure.
  logic              start;
  logic              busy;
  logic              done;
  logic              mine_re;
  logic [ADDR_W-1:0] mine_addr;
  logic              mine_rd_data;
  logic              cnt_we;
  logic [ADDR_W-1:0] cnt_addr;
  logic [3:0]        cnt_wdata;

  modport master (
    input  start, mine_rd_data,
    output busy, done, mine_re, mine_addr, cnt_we, cnt_addr, cnt_wdata
  );

  modport slave (
    output start, mine_rd_data,
    input  busy, done, mine_re, mine_addr, cnt_we, cnt_addr, cnt_wdata
  );
endinterface

// File: rtl/neighbor_offset_gen.sv
// Maps (row, col, probe index) to the probed tile address and whether that
// tile lies on the board; off-board probes report address 0.
module neighbor_offset_gen #(
  parameter int ROWS   = neighbor_counter_pkg::ROWS,
  parameter int COLS   = neighbor_counter_pkg::COLS,
  parameter int ADDR_W = neighbor_counter_pkg::addr_width(ROWS, COLS),
  parameter int ROW_W  = $clog2(ROWS),
  parameter int COL_W  = $clog2(COLS)
) (
  input  logic [ROW_W-1:0]  row_i,
  input  logic [COL_W-1:0]  col_i,
  input  logic [3:0]        k_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_bounds_o
);
  import neighbor_counter_pkg::*;

  localparam logic signed [ROW_W:0] ROW_MAX = (ROW_W+1)'(ROWS - 1);
  localparam logic signed [COL_W:0] COL_MAX = (COL_W+1)'(COLS - 1);

  logic signed [ROW_W:0] nr;
  logic signed [COL_W:0] nc;

  // One extra signed bit lets -1 and ROWS/COLS fall outside the legal range.
  always_comb begin
    nr          = $signed({1'b0, row_i}) + (ROW_W+1)'(DR_TAB[k_i]);
    nc          = $signed({1'b0, col_i}) + (COL_W+1)'(DC_TAB[k_i]);
    in_bounds_o = !nr[ROW_W] && (nr <= ROW_MAX) && !nc[COL_W] && (nc <= COL_MAX);
    addr_o      = '0;
    if (in_bounds_o) begin
      addr_o = ADDR_W'(nr[ROW_W-1:0]) * ADDR_W'(COLS) + ADDR_W'(nc[COL_W-1:0]);
    end
  end

endmodule

// File: rtl/neighbor_counter.sv
// Scans the mine bitmap once per game and writes each tile's adjacent-mine
// count (or the mine marker) into the count RAM, 11 cycles per tile.
module neighbor_counter #(
  parameter int         COLS      = neighbor_counter_pkg::COLS,
  parameter int         ROWS      = neighbor_counter_pkg::ROWS,
  parameter int         ADDR_W    = neighbor_counter_pkg::addr_width(ROWS, COLS),
  parameter logic [3:0] MINE_CODE = neighbor_counter_pkg::MINE_CODE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  neighbor_counter_if.master           bus,
  output neighbor_counter_pkg::state_t state_o
);
  import neighbor_counter_pkg::*;

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [3:0]          k_q, k_d;
  logic [3:0]          acc_q, acc_d;
  logic                mine_q, mine_d;
  logic                pend_q, pend_d;
  logic                centre_q, centre_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mine_re_q, mine_re_d;
  logic [ADDR_W-1:0]   mine_addr_q, mine_addr_d;
  logic                cnt_we_q, cnt_we_d;
  logic [ADDR_W-1:0]   cnt_addr_q, cnt_addr_d;
  logic [3:0]          cnt_wdata_q, cnt_wdata_d;
  logic [ADDR_W-1:0]   probe_addr;
  logic                probe_ok;
  logic                last_col, last_tile;

  // The probe for the cycle being entered is computed from next-state
  // coordinates so mine_re/mine_addr can leave the design registered.
  neighbor_offset_gen #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .COL_W(COL_W)
  ) u_offset (
    .row_i       (row_d),
    .col_i       (col_d),
    .k_i         (k_d),
    .addr_o      (probe_addr),
    .in_bounds_o (probe_ok)
  );

  assign last_col  = (col_q == COL_W'(COLS - 1));
  assign last_tile = last_col && (row_q == ROW_W'(ROWS - 1));

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    k_d         = k_q;
    acc_d       = acc_q;
    mine_d      = mine_q;
    cnt_we_d    = 1'b0;
    cnt_addr_d  = cnt_addr_q;
    cnt_wdata_d = cnt_wdata_q;
    pend_d      = mine_re_q;
    centre_d    = (state_q == ST_READ) && (k_q == 4'd0);

    if (pend_q) begin
      if (centre_q) mine_d = bus.mine_rd_data;
      else          acc_d  = acc_q + {3'b000, bus.mine_rd_data};
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_READ;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
        end
      end
      ST_READ: begin
        if (k_q == 4'd8) state_d = ST_DRAIN;
        else             k_d     = k_q + 4'd1;
      end
      ST_DRAIN: begin
        state_d     = ST_WRITE;
        cnt_we_d    = 1'b1;
        cnt_addr_d  = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
        cnt_wdata_d = mine_d ? MINE_CODE : acc_d;
      end
      ST_WRITE: begin
        acc_d  = '0;
        mine_d = 1'b0;
        k_d    = '0;
        if (last_col) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        state_d = last_tile ? ST_DONE : ST_READ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    mine_re_d   = (state_d == ST_READ) && probe_ok;
    mine_addr_d = mine_re_d ? probe_addr : '0;
    busy_d      = (state_d == ST_READ) || (state_d == ST_DRAIN) || (state_d == ST_WRITE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      mine_q      <= 1'b0;
      pend_q      <= 1'b0;
      centre_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mine_re_q   <= 1'b0;
      mine_addr_q <= '0;
      cnt_we_q    <= 1'b0;
      cnt_addr_q  <= '0;
      cnt_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      mine_q      <= mine_d;
      pend_q      <= pend_d;
      centre_q    <= centre_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mine_re_q   <= mine_re_d;
      mine_addr_q <= mine_addr_d;
      cnt_we_q    <= cnt_we_d;
      cnt_addr_q  <= cnt_addr_d;
      cnt_wdata_q <= cnt_wdata_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mine_re   = mine_re_q;
  assign bus.mine_addr = mine_addr_q;
  assign bus.cnt_we    = cnt_we_q;
  assign bus.cnt_addr  = cnt_addr_q;
  assign bus.cnt_wdata = cnt_wdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_neighbor_counter.sv
// Bench for neighbor_counter: board-level reference model, RAM model and
// scenario tasks covering empty, edge, dense, random and reset-abort boards.
module tb_neighbor_counter;
  import neighbor_counter_pkg::*;

  localparam int N      = ROWS * COLS;
  localparam int AW     = addr_width(ROWS, COLS);
  localparam int W      = AW + 4;
  localparam int BUDGET = 11 * N + 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  state_t dbg_state;

  neighbor_counter_if #(.ADDR_W(AW)) bus ();

  neighbor_counter u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- mine RAM model ----------------
  bit   mines [N];
  logic rd_q = 1'b0;
  always @(posedge clk) begin
    if (bus.mine_re) rd_q <= mines[bus.mine_addr];
    else             rd_q <= 1'($urandom_range(0, 1));
  end
  assign bus.mine_rd_data = rd_q;

  // ---------------- monitor ----------------
  logic [W-1:0]  wr_q[$];
  int            wr_cyc_q[$];
  logic [AW-1:0] probe_q[$];
  int            done_cyc_q[$];
  logic [3:0]    cnt_ram [N];
  int busy_first, busy_last, busy_cnt, bad_addr_cnt;

  always @(negedge clk) begin
    if (bus.cnt_we) begin
      wr_q.push_back({bus.cnt_addr, bus.cnt_wdata});
      wr_cyc_q.push_back(cyc);
      cnt_ram[bus.cnt_addr] = bus.cnt_wdata;
    end
    if (bus.mine_re) probe_q.push_back(bus.mine_addr);
    else if (bus.mine_addr != '0) bad_addr_cnt++;
    if (bus.done) done_cyc_q.push_back(cyc);
    if (bus.busy) begin
      if (busy_cnt == 0) busy_first = cyc;
      busy_last = cyc;
      busy_cnt++;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_probe_q[$];

  function automatic bit on_board(int r, int c);
    return (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
  endfunction

  task automatic build_expected();
    exp_q.delete();
    exp_probe_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int cnt = 0;
        exp_probe_q.push_back(AW'(r * COLS + c));
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && on_board(r + dr, c + dc)) begin
              exp_probe_q.push_back(AW'((r + dr) * COLS + c + dc));
              cnt += int'(mines[(r + dr) * COLS + c + dc]);
            end
          end
        end
        exp_q.push_back({AW'(r * COLS + c), mines[r * COLS + c] ? 4'hF : 4'(cnt)});
      end
    end
  endtask

  task automatic clear_monitor();
    wr_q.delete();
    wr_cyc_q.delete();
    probe_q.delete();
    done_cyc_q.delete();
    busy_cnt = 0;
    busy_first = 0;
    busy_last = 0;
    bad_addr_cnt = 0;
    for (int i = 0; i < N; i++) cnt_ram[i] = 4'h0;
  endtask

  task automatic clear_board();
    for (int i = 0; i < N; i++) mines[i] = 1'b0;
  endtask

  task automatic random_board(int pct);
    for (int i = 0; i < N; i++) mines[i] = ($urandom_range(0, 99) < pct);
  endtask

  // Full scan with optional extra start pulses; checks every write and timing.
  task automatic run_scan(string name, int mid_pulse, bit pulse_at_done);
    int  t0;
    bit  timeout;
    build_expected();
    clear_monitor();
    @(negedge clk);
    t0 = cyc;
    bus.start = 1'b1;
    timeout = 1'b1;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (bus.done) begin
        timeout = 1'b0;
        bus.start = pulse_at_done;
        break;
      end
      bus.start = (mid_pulse > 0) && (cyc == t0 + mid_pulse);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);

    tests++;
    if (timeout) begin
      fails++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, BUDGET);
    end
    tests++;
    if (wr_q.size() != N) begin
      fails++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_q.size(), N);
    end
    for (int i = 0; i < wr_q.size() && i < N; i++) begin
      tests++;
      if (wr_q[i] !== exp_q[i]) begin
        fails++;
        if (fails <= 20)
          $display("FAIL %s write[%0d]: got addr=%0d data=%0h expected addr=%0d data=%0h",
                   name, i, wr_q[i][W-1:4], wr_q[i][3:0], exp_q[i][W-1:4], exp_q[i][3:0]);
      end
      tests++;
      if (wr_cyc_q[i] != t0 + 11 * (i + 1)) begin
        fails++;
        if (fails <= 20)
          $display("FAIL %s write_cycle[%0d]: got %0d expected %0d",
                   name, i, wr_cyc_q[i] - t0, 11 * (i + 1));
      end
    end
    tests++;
    if (done_cyc_q.size() != 1) begin
      fails++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cyc_q.size());
    end else begin
      tests++;
      if (done_cyc_q[0] != t0 + 11 * N + 1) begin
        fails++;
        $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc_q[0] - t0, 11 * N + 1);
      end
    end
    tests++;
    if (busy_cnt != 11 * N || busy_first != t0 + 1 || busy_last != t0 + 11 * N) begin
      fails++;
      $display("FAIL %s busy_window: got first=%0d last=%0d count=%0d expected %0d %0d %0d",
               name, busy_first - t0, busy_last - t0, busy_cnt, 1, 11 * N, 11 * N);
    end
    tests++;
    if (probe_q.size() != exp_probe_q.size()) begin
      fails++;
      $display("FAIL %s probe_count: got %0d expected %0d", name, probe_q.size(), exp_probe_q.size());
    end else begin
      for (int i = 0; i < probe_q.size(); i++) begin
        tests++;
        if (probe_q[i] !== exp_probe_q[i]) begin
          fails++;
          if (fails <= 20)
            $display("FAIL %s probe[%0d]: got %0d expected %0d", name, i, probe_q[i], exp_probe_q[i]);
        end
      end
    end
    tests++;
    if (bad_addr_cnt != 0) begin
      fails++;
      $display("FAIL %s idle_mine_addr: got %0d nonzero addresses with mine_re low expected 0",
               name, bad_addr_cnt);
    end
  endtask

  task automatic check_tile(string name, int r, int c, logic [3:0] want);
    tests++;
    if (cnt_ram[r * COLS + c] !== want) begin
      fails++;
      $display("FAIL %s tile(%0d,%0d): got %0h expected %0h", name, r, c, cnt_ram[r * COLS + c], want);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.busy, bus.done, bus.mine_re, bus.cnt_we} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_strobes: got busy/done/re/we=%b expected 0000",
               {bus.busy, bus.done, bus.mine_re, bus.cnt_we});
    end
    tests++;
    if (bus.mine_addr !== '0 || bus.cnt_addr !== '0 || bus.cnt_wdata !== 4'h0) begin
      fails++;
      $display("FAIL reset_buses: got mine_addr=%0d cnt_addr=%0d cnt_wdata=%0h expected 0 0 0",
               bus.mine_addr, bus.cnt_addr, bus.cnt_wdata);
    end
    tests++;
    if (dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    // start high while the edge still sees reset asserted must be dropped
    bus.start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL start_in_reset: got busy=%b state=%0d expected 0 %0d", bus.busy, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_empty();
    clear_board();
    run_scan("empty", 0, 1'b0);
  endtask

  task automatic test_single_mine();
    clear_board();
    mines[5 * COLS + 5] = 1'b1;
    run_scan("single", 0, 1'b0);
    check_tile("single", 5, 5, 4'hF);
    check_tile("single", 4, 4, 4'h1);
    check_tile("single", 6, 6, 4'h1);
    check_tile("single", 7, 5, 4'h0);
  endtask

  task automatic test_corner();
    clear_board();
    mines[0] = 1'b1;
    mines[1] = 1'b1;
    run_scan("corner", 0, 1'b0);
    check_tile("corner", 0, 0, 4'hF);
    check_tile("corner", 0, 1, 4'hF);
    check_tile("corner", 0, 2, 4'h1);
    check_tile("corner", 1, 0, 4'h2);
    check_tile("corner", 1, 1, 4'h2);
    check_tile("corner", 1, 2, 4'h1);
  endtask

  task automatic test_full_ring();
    clear_board();
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (dr != 0 || dc != 0) mines[(8 + dr) * COLS + 8 + dc] = 1'b1;
    mines[(ROWS - 1) * COLS + COLS - 1] = 1'b1;
    run_scan("ring", 0, 1'b0);
    check_tile("ring", 8, 8, 4'h8);
    check_tile("ring", ROWS - 1, COLS - 1, 4'hF);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      random_board($urandom_range(10, 60));
      run_scan("random", 0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    random_board(30);
    run_scan("restart_ignored", $urandom_range(100, 2500), 1'b1);
  endtask

  task automatic test_reset_mid_scan();
    int t0;
    random_board(25);
    build_expected();
    clear_monitor();
    @(negedge clk);
    t0 = cyc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t0 + 40 * 11 + 4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.cnt_we !== 1'b0 || bus.mine_re !== 1'b0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL abort_outputs: got busy=%b we=%b re=%b state=%0d expected 0 0 0 %0d",
               bus.busy, bus.cnt_we, bus.mine_re, dbg_state, ST_IDLE);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (wr_q.size() != 40) begin
      fails++;
      $display("FAIL abort_write_count: got %0d expected 40", wr_q.size());
    end
    for (int i = 0; i < wr_q.size() && i < 40; i++) begin
      tests++;
      if (wr_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL abort_write[%0d]: got %0h expected %0h", i, wr_q[i], exp_q[i]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    random_board(40);
    run_scan("after_abort", 0, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_empty();
    test_single_mine();
    test_corner();
    test_full_ring();
    test_random();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
